// File: rtl/cursor_frame_scheduler_pkg.sv
// rtl/cursor_frame_scheduler_pkg.sv - shared states, button indices and limits for the cursor scheduler
package cursor_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    APPLY_POS,
    APPLY_COL,
    DONE,
    WAIT
  } state_t;

  localparam int BTN_UP    = 4;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_CNTR  = 0;

  localparam logic signed [3:0] ACC_MAX = 4'sd7;
  localparam logic signed [3:0] ACC_MIN = -4'sd7;

  function automatic logic [7:0] center_pos(input int sq_size);
    return 8'((256 - sq_size) / 2);
  endfunction

  localparam logic [7:0] CENTER = center_pos(16);

endpackage

// File: rtl/cursor_knob_accum.sv
// rtl/cursor_knob_accum.sv - saturating signed rotary accumulator, cleared once per frame snapshot
module cursor_knob_accum
  import cursor_frame_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              strobe,
  input  logic              dir,
  output logic signed [3:0] acc
);

  logic signed [3:0] step;
  assign step = dir ? 4'sd1 : -4'sd1;

  // A strobe landing on the clear cycle seeds the fresh value instead of being lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 4'sd0;
    end else if (clear) begin
      acc <= strobe ? step : 4'sd0;
    end else if (strobe) begin
      if (dir && acc != ACC_MAX) begin
        acc <= acc + 4'sd1;
      end else if (!dir && acc != ACC_MIN) begin
        acc <= acc - 4'sd1;
      end
    end
  end

endmodule

// File: rtl/cursor_frame_scheduler.sv
// rtl/cursor_frame_scheduler.sv - latches button/rotary requests and applies them once per frame after the picture
module cursor_frame_scheduler
  import cursor_frame_scheduler_pkg::*;
#(
  parameter int         STEP         = 4,
  parameter int         SQ_SIZE      = 16,
  parameter int         TRIGGER_LINE = 396,
  parameter logic [2:0] RESET_COLOR  = 3'b100
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [4:0] iBTN,
  input  logic [1:0] iKnob,
  input  logic [9:0] iVcounter,
  input  logic [9:0] iHcounter,
  output logic [7:0] oXRedCounter,
  output logic [7:0] oYRedCounter,
  output logic [2:0] oColorCuadro,
  output logic       oUpdate,
  output logic       oPending
);

  localparam logic [7:0]        CTR     = center_pos(SQ_SIZE);
  localparam logic signed [8:0] MAX_POS = 9'(256 - SQ_SIZE);
  localparam logic signed [8:0] STEP_S  = 9'(STEP);

  state_t            state;
  logic [4:0]        btn_prev;
  logic [4:0]        pending;
  logic [4:0]        work_btn;
  logic [2:0]        work_delta;
  logic [4:0]        rise;
  logic signed [3:0] acc;
  logic              snap;

  assign rise     = iBTN & ~btn_prev;
  assign snap     = (state == SNAP);
  assign oPending = (|pending) || (acc != 4'sd0);

  cursor_knob_accum u_rot_accum (
    .clk    (Clock),
    .rst    (Reset),
    .clear  (snap),
    .strobe (iKnob[1]),
    .dir    (iKnob[0]),
    .acc    (acc)
  );

  // Opposing presses cancel; result is clamped to the visible range, never wrapped.
  function automatic logic [7:0] move(input logic [7:0] pos, input logic dec, input logic inc);
    logic signed [8:0] p;
    p = {1'b0, pos};
    if (dec && !inc) begin
      p = p - STEP_S;
    end else if (inc && !dec) begin
      p = p + STEP_S;
    end
    if (p[8]) begin
      return 8'd0;
    end else if (p > MAX_POS) begin
      return MAX_POS[7:0];
    end
    return p[7:0];
  endfunction

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      btn_prev <= '0;
      pending  <= '0;
    end else begin
      btn_prev <= iBTN;
      pending  <= snap ? rise : (pending | rise);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      oXRedCounter <= CTR;
      oYRedCounter <= CTR;
      oColorCuadro <= RESET_COLOR;
      oUpdate      <= 1'b0;
      work_btn     <= '0;
      work_delta   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iVcounter == 10'(TRIGGER_LINE) && iHcounter == '0) state <= SNAP;
        end
        SNAP: begin
          work_btn   <= pending;
          // Colour wraps mod 8, so only the low three accumulator bits matter.
          work_delta <= acc[2:0];
          state      <= APPLY_POS;
        end
        APPLY_POS: begin
          if (work_btn[BTN_CNTR]) begin
            oXRedCounter <= CTR;
            oYRedCounter <= CTR;
          end else begin
            oXRedCounter <= move(oXRedCounter, work_btn[BTN_LEFT], work_btn[BTN_RIGHT]);
            oYRedCounter <= move(oYRedCounter, work_btn[BTN_UP], work_btn[BTN_DOWN]);
          end
          state <= APPLY_COL;
        end
        APPLY_COL: begin
          oColorCuadro <= oColorCuadro + work_delta;
          oUpdate      <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          oUpdate <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (iVcounter != 10'(TRIGGER_LINE)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
